// File: rtl/axis_len_pkg.sv
// Shared types for the AXI-stream length trim/pad block.
package axis_len_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2,
    PAD  = 2'd3
  } state_t;

endpackage

// File: rtl/axis_len_if.sv
// AXI-stream bundle; the master drives payload and valid, the slave drives ready.
interface axis_if #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1
);
  logic [DSIZE-1:0] tdata;
  logic [KSIZE-1:0] tkeep;
  logic [USIZE-1:0] tuser;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_length_trim_pad_skid.sv
// Two-entry registered ready/valid buffer: fully registered outputs, one beat per cycle.
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;

  assign in_ready = !skid_valid;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (out_ready || !out_valid) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) out_data <= in_data;
        end
      end else if (in_valid && in_ready) begin
        // Output is stalled: park the incoming beat so in_ready can stay registered.
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end
endmodule

// File: rtl/axis_length_trim_pad.sv
// Forces each packet to exactly len_q beats by truncating (cut) or appending fill beats (pad).
// Handshake: a beat moves on either side only in a cycle where tvalid && tready.
module axis_length_trim_pad
  import axis_len_pkg::*;
#(
  parameter int               DSIZE     = 32,
  parameter int               KSIZE     = DSIZE / 8,
  parameter int               USIZE     = 1,
  parameter int               LSIZE     = 16,
  parameter logic [DSIZE-1:0] PAD_VALUE = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [LSIZE-1:0] length,
  input  logic             cut_en,
  input  logic             pad_en,
  axis_if.slave            s,
  axis_if.master           m,
  output logic             cut_pulse,
  output logic             pad_pulse,
  output logic             busy,
  output state_t           state
);
  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic [KSIZE-1:0] keep;
    logic [USIZE-1:0] user;
    logic             last;
  } beat_t;

  localparam int BW = $bits(beat_t);

  logic [LSIZE-1:0] cnt, len_q;
  logic             cut_q, pad_q, over_q;
  logic             skid_ready, push, accept, at_end;
  beat_t            beat_in, beat_out;

  assign s.tready = !rst && ((state == DROP) || (state != PAD && skid_ready));
  assign accept   = s.tvalid && s.tready;
  assign at_end   = (cnt == len_q - 1'b1);
  assign busy     = (state != IDLE);

  always_comb begin
    beat_in = '{data: s.tdata, keep: s.tkeep, user: s.tuser, last: s.tlast};
    push    = 1'b0;
    case (state)
      IDLE: begin
        push = accept && (length != '0);
        if (length == LSIZE'(1)) beat_in.last = 1'b1;
        else if (s.tlast && pad_en) beat_in.last = 1'b0;
      end
      PASS: begin
        push = accept;
        // over_q: length already reached without cut, forward the rest untouched.
        if (!over_q) begin
          if (at_end) beat_in.last = 1'b1;
          else if (s.tlast && pad_q) beat_in.last = 1'b0;
        end
      end
      PAD: begin
        push    = skid_ready;
        beat_in = '{data: PAD_VALUE, keep: {KSIZE{1'b1}}, user: {USIZE{1'b0}}, last: at_end};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      cut_q     <= 1'b0;
      pad_q     <= 1'b0;
      over_q    <= 1'b0;
      cut_pulse <= 1'b0;
      pad_pulse <= 1'b0;
    end else begin
      cut_pulse <= 1'b0;
      pad_pulse <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          len_q  <= length;
          cut_q  <= cut_en;
          pad_q  <= pad_en;
          over_q <= 1'b0;
          cnt    <= '0;
          if (length == '0) begin
            if (!s.tlast) state <= DROP;
          end else if (length == LSIZE'(1)) begin
            if (!s.tlast) begin
              if (cut_en) begin
                cut_pulse <= 1'b1;
                state     <= DROP;
              end else begin
                over_q <= 1'b1;
                state  <= PASS;
              end
            end
          end else if (s.tlast) begin
            if (pad_en) begin
              pad_pulse <= 1'b1;
              cnt       <= LSIZE'(1);
              state     <= PAD;
            end
          end else begin
            cnt   <= LSIZE'(1);
            state <= PASS;
          end
        end
        PASS: if (accept) begin
          if (over_q) begin
            if (s.tlast) begin
              over_q <= 1'b0;
              state  <= IDLE;
            end
          end else if (at_end) begin
            cnt <= '0;
            if (s.tlast) state <= IDLE;
            else if (cut_q) begin
              cut_pulse <= 1'b1;
              state     <= DROP;
            end else over_q <= 1'b1;
          end else if (s.tlast) begin
            if (pad_q) begin
              pad_pulse <= 1'b1;
              cnt       <= cnt + 1'b1;
              state     <= PAD;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end else cnt <= cnt + 1'b1;
        end
        DROP: if (accept && s.tlast) state <= IDLE;
        PAD: if (skid_ready) begin
          if (at_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_skid_reg #(.W(BW)) u_skid (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .in_data   (beat_in),
    .out_valid (m.tvalid),
    .out_ready (m.tready),
    .out_data  (beat_out)
  );

  assign m.tdata = beat_out.data;
  assign m.tkeep = beat_out.keep;
  assign m.tuser = beat_out.user;
  assign m.tlast = beat_out.last;
endmodule

// File: tb/tb_axis_length_trim_pad.sv
// Directed bench for axis_length_trim_pad: cut, pad, exact fit, drop, random-ready soak, mid-packet reset.
module tb_axis_length_trim_pad;
  import axis_len_pkg::*;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] length = '0;
  logic        cut_en = 1'b0, pad_en = 1'b0;
  logic        cut_pulse, pad_pulse, busy;
  state_t      state;

  axis_if s_if ();
  axis_if m_if ();

  axis_length_trim_pad dut (
    .clock     (clock),
    .rst       (rst),
    .length    (length),
    .cut_en    (cut_en),
    .pad_en    (pad_en),
    .s         (s_if),
    .m         (m_if),
    .cut_pulse (cut_pulse),
    .pad_pulse (pad_pulse),
    .busy      (busy),
    .state     (state)
  );

  always #5 clock = ~clock;

  int          checks = 0, failures = 0, timeouts = 0;
  logic [37:0] exp_q[$];
  logic [37:0] out_q[$];
  int          in_acc, cut_cnt, pad_cnt, busy_cyc, pad_hold, stall_err;
  logic        rand_rdy = 1'b0, rdy_fixed = 1'b1;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_rec, cur_rec;

  function automatic logic [37:0] rec(input logic [31:0] d, input logic [3:0] k,
                                      input logic u, input logic l);
    return {d, k, u, l};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_queue(input string tag);
    check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  task automatic clear();
    out_q.delete();
    exp_q.delete();
    in_acc = 0; cut_cnt = 0; pad_cnt = 0; busy_cyc = 0; pad_hold = 0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      s_if.tdata  = base + i;
      s_if.tlast  = with_last && (i == n - 1);
      s_if.tkeep  = s_if.tlast ? 4'h3 : 4'hF;
      s_if.tuser  = i[0];
      s_if.tvalid = 1'b1;
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!s_if.tready && t < 2000);
      if (t >= 2000) timeouts++;
      @(posedge clock); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while ((m_if.tvalid || busy) && t < 2000);
    if (t >= 2000) timeouts++;
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
  endtask

  // Output ready: fixed level or 50% random, updated just after each rising edge.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clock); #2;
      m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  always @(negedge clock) begin
    cur_rec = {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_if.tvalid || cur_rec !== prev_rec)) stall_err++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_rec   = cur_rec;
      if (m_if.tvalid && m_if.tready) out_q.push_back(cur_rec);
      if (s_if.tvalid && s_if.tready) in_acc++;
      if (cut_pulse) cut_cnt++;
      if (pad_pulse) pad_cnt++;
      if (busy) busy_cyc++;
      if (state == PAD && !s_if.tready) pad_hold++;
    end
  end

  initial begin
    int n, exp_cut, exp_pad, bad;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    stall_err = 0;
    clear();

    repeat (3) @(posedge clock); #1;
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {cut_pulse, pad_pulse}, 0);
    rst = 1'b0;
    @(posedge clock); #1;
    check("idle_s_tready", s_if.tready, 1);

    // Truncation: 6 beats into length 4.
    clear();
    length = 16'd4; cut_en = 1'b1; pad_en = 1'b0;
    send_pkt(6, 32'h100, 1'b1);
    drain();
    exp_q.push_back(rec(32'h100, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h101, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(rec(32'h102, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h103, 4'hF, 1'b1, 1'b1));
    check_queue("cut");
    check("cut_cut_pulses", 64'(cut_cnt), 1);
    check("cut_pad_pulses", 64'(pad_cnt), 0);
    check("cut_in_beats", 64'(in_acc), 6);

    // Padding: 3 beats into length 5.
    clear();
    length = 16'd5; cut_en = 1'b0; pad_en = 1'b1;
    send_pkt(3, 32'h200, 1'b1);
    drain();
    exp_q.push_back(rec(32'h200, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h201, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(rec(32'h202, 4'h3, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h0, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h0, 4'hF, 1'b0, 1'b1));
    check_queue("pad");
    check("pad_pad_pulses", 64'(pad_cnt), 1);
    check("pad_cut_pulses", 64'(cut_cnt), 0);
    check("pad_tready_low", 64'(pad_hold), 2);

    // Exact fits, then back-to-back length 1 and length 2 packets.
    clear();
    length = 16'd3; cut_en = 1'b1; pad_en = 1'b1;
    send_pkt(3, 32'h300, 1'b1);
    length = 16'd1;
    send_pkt(1, 32'h400, 1'b1);
    length = 16'd2;
    send_pkt(2, 32'h500, 1'b1);
    drain();
    exp_q.push_back(rec(32'h300, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h301, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(rec(32'h302, 4'h3, 1'b0, 1'b1));
    exp_q.push_back(rec(32'h400, 4'h3, 1'b0, 1'b1));
    exp_q.push_back(rec(32'h500, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h501, 4'h3, 1'b1, 1'b1));
    check_queue("fit");
    check("fit_pulses", 64'(cut_cnt + pad_cnt), 0);

    // Zero length: whole packet consumed, nothing emitted.
    clear();
    length = 16'd0; cut_en = 1'b0; pad_en = 1'b0;
    send_pkt(4, 32'h600, 1'b1);
    drain();
    check("zero_out_beats", 64'(out_q.size()), 0);
    check("zero_in_beats", 64'(in_acc), 4);
    check("zero_busy_cycles", 64'(busy_cyc), 3);
    check("zero_pulses", 64'(cut_cnt + pad_cnt), 0);

    // Soak: length 8, random sizes, random output ready.
    clear();
    length = 16'd8; cut_en = 1'b1; pad_en = 1'b1;
    rand_rdy = 1'b1;
    exp_cut = 0; exp_pad = 0;
    for (int p = 0; p < 200; p++) begin
      n = $urandom_range(1, 16);
      if (n > 8) exp_cut++;
      if (n < 8) exp_pad++;
      for (int i = 0; i < 8; i++) begin
        if (i < n) exp_q.push_back(rec(32'(p << 8) + 32'(i), (i == n - 1) ? 4'h3 : 4'hF, i[0], i == 7));
        else exp_q.push_back(rec(32'h0, 4'hF, 1'b0, i == 7));
      end
      send_pkt(n, 32'(p << 8), 1'b1);
    end
    rand_rdy = 1'b0;
    drain();
    check("soak_count", 64'(out_q.size()), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      if (out_q[i] !== exp_q[i]) bad++;
    check("soak_beats_wrong", 64'(bad), 0);
    check("soak_cut_pulses", 64'(cut_cnt), 64'(exp_cut));
    check("soak_pad_pulses", 64'(pad_cnt), 64'(exp_pad));
    check("soak_stall_changes", 64'(stall_err), 0);

    // Reset in the middle of padding, with the output stalled.
    clear();
    rdy_fixed = 1'b0;
    length = 16'd8; cut_en = 1'b0; pad_en = 1'b1;
    send_pkt(1, 32'h700, 1'b1);
    repeat (3) @(posedge clock); #1;
    check("midpad_state", state, PAD);
    check("midpad_m_tvalid_before", m_if.tvalid, 1);
    rst = 1'b1; #1;
    check("midpad_rst_m_tvalid", m_if.tvalid, 0);
    check("midpad_rst_busy", busy, 0);
    check("midpad_rst_s_tready", s_if.tready, 0);
    @(posedge clock); #1;
    rst = 1'b0; rdy_fixed = 1'b1;
    repeat (2) @(posedge clock); #1;
    clear();
    length = 16'd2; pad_en = 1'b0;
    send_pkt(2, 32'h800, 1'b1);
    drain();
    exp_q.push_back(rec(32'h800, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'h801, 4'h3, 1'b1, 1'b1));
    check_queue("after_pad_rst");

    // Reset in the middle of a passing packet.
    clear();
    length = 16'd8; cut_en = 1'b1; pad_en = 1'b1;
    send_pkt(3, 32'h900, 1'b0);
    check("midpass_state", state, PASS);
    check("midpass_m_tvalid_before", m_if.tvalid, 1);
    rst = 1'b1; #1;
    check("midpass_rst_m_tvalid", m_if.tvalid, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    repeat (2) @(posedge clock); #1;
    clear();
    length = 16'd2; cut_en = 1'b0; pad_en = 1'b0;
    send_pkt(2, 32'hA00, 1'b1);
    drain();
    exp_q.push_back(rec(32'hA00, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(rec(32'hA01, 4'h3, 1'b1, 1'b1));
    check_queue("after_pass_rst");
    check("after_rst_pulses", 64'(cut_cnt + pad_cnt), 0);

    check("wait_timeouts", 64'(timeouts), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
